// File: rtl/fma_scheduler.sv
// Round-robin scheduler sharing one fixed-latency FMA pipeline between NREQ requesters.
// Credits bound in-flight ops plus queued results so the result FIFO can never overflow.
module fma_scheduler #(
    parameter int NREQ                 = 4,
    parameter int TE_BITS              = 7,
    parameter int MANT_SIZE            = 14,
    parameter int MANT_ADD_RESULT_SIZE = 30,
    parameter int FMA_LATENCY          = 2,
    parameter int RES_DEPTH            = 4,
    parameter int ID_W                 = $clog2(NREQ)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NREQ-1:0]                 req_valid_i,
    output logic [NREQ-1:0]                 req_ready_o,
    input  logic [NREQ*TE_BITS-1:0]         req_te1_i,
    input  logic [NREQ*TE_BITS-1:0]         req_te2_i,
    input  logic [NREQ*TE_BITS-1:0]         req_te3_i,
    input  logic [NREQ*MANT_SIZE-1:0]       req_mant1_i,
    input  logic [NREQ*MANT_SIZE-1:0]       req_mant2_i,
    input  logic [NREQ*MANT_SIZE-1:0]       req_mant3_i,
    input  logic [NREQ-1:0]                 req_opp_sign_i,
    output logic [TE_BITS-1:0]              fma_te1_o,
    output logic [TE_BITS-1:0]              fma_te2_o,
    output logic [TE_BITS-1:0]              fma_te3_o,
    output logic [MANT_SIZE-1:0]            fma_mant1_o,
    output logic [MANT_SIZE-1:0]            fma_mant2_o,
    output logic [MANT_SIZE-1:0]            fma_mant3_o,
    output logic                            fma_opp_sign_o,
    input  logic [MANT_ADD_RESULT_SIZE-1:0] fma_mant_i,
    input  logic [TE_BITS-1:0]              fma_te_i,
    input  logic                            fma_frac_truncated_i,
    output logic                            res_valid_o,
    input  logic                            res_ready_i,
    output logic [ID_W-1:0]                 res_id_o,
    output logic [MANT_ADD_RESULT_SIZE-1:0] res_mant_o,
    output logic [TE_BITS-1:0]              res_te_o,
    output logic                            res_frac_truncated_o,
    output logic                            busy_o
);

    localparam int CNT_W = $clog2(RES_DEPTH + 1);
    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RES_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RES_DEPTH - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NREQ - 1);
    localparam logic [ID_W:0]    NREQ_C   = (ID_W + 1)'(NREQ);

    typedef struct packed {
        logic [ID_W-1:0]                 id;
        logic [MANT_ADD_RESULT_SIZE-1:0] mant;
        logic [TE_BITS-1:0]              te;
        logic                            trunc;
    } res_entry_t;

    logic [ID_W-1:0]                      rr_q, rr_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [TE_BITS-1:0]                   te1_q, te1_d, te2_q, te2_d, te3_q, te3_d;
    logic [MANT_SIZE-1:0]                 mant1_q, mant1_d, mant2_q, mant2_d, mant3_q, mant3_d;
    logic                                 opp_q, opp_d;
    logic                                 issue_v_q, issue_v_d;
    logic [ID_W-1:0]                      issue_id_q, issue_id_d;
    logic [FMA_LATENCY-1:0]               pipe_v_q, pipe_v_d;
    logic [FMA_LATENCY-1:0][ID_W-1:0]     pipe_id_q, pipe_id_d;
    res_entry_t [RES_DEPTH-1:0]           mem_q, mem_d;
    logic [PTR_W-1:0]                     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                     fifo_cnt_q, fifo_cnt_d;

    logic            issue_ok;
    logic            any_valid;
    logic            accept;
    logic            push;
    logic            pop;
    logic [ID_W-1:0] win;

    // Scan downward in offset so the smallest offset from rr_q is the last hit and wins.
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        win       = '0;
        any_valid = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            sum = {1'b0, rr_q} + (ID_W + 1)'(off);
            if (sum >= NREQ_C) begin
                sum = sum - NREQ_C;
            end
            idx = sum[ID_W-1:0];
            if (req_valid_i[idx]) begin
                any_valid = 1'b1;
                win       = idx;
            end
        end
    end

    assign issue_ok    = !rst_i && (cnt_q < DEPTH_C);
    assign accept      = issue_ok && any_valid;
    assign req_ready_o = accept ? (NREQ'(1) << win) : '0;

    assign push        = pipe_v_q[FMA_LATENCY-1];
    assign res_valid_o = (fifo_cnt_q != '0);
    assign pop         = res_valid_o && res_ready_i;

    always_comb begin
        rr_d       = rr_q;
        te1_d      = te1_q;
        te2_d      = te2_q;
        te3_d      = te3_q;
        mant1_d    = mant1_q;
        mant2_d    = mant2_q;
        mant3_d    = mant3_q;
        opp_d      = opp_q;
        issue_v_d  = accept;
        issue_id_d = issue_id_q;
        if (accept) begin
            rr_d       = (win == LAST_ID) ? '0 : win + ID_W'(1);
            te1_d      = req_te1_i[int'(win)*TE_BITS +: TE_BITS];
            te2_d      = req_te2_i[int'(win)*TE_BITS +: TE_BITS];
            te3_d      = req_te3_i[int'(win)*TE_BITS +: TE_BITS];
            mant1_d    = req_mant1_i[int'(win)*MANT_SIZE +: MANT_SIZE];
            mant2_d    = req_mant2_i[int'(win)*MANT_SIZE +: MANT_SIZE];
            mant3_d    = req_mant3_i[int'(win)*MANT_SIZE +: MANT_SIZE];
            opp_d      = req_opp_sign_i[win];
            issue_id_d = win;
        end
    end

    // The tracking pipe mirrors the FMA latency so its tail lines up with fma_*_i.
    always_comb begin
        pipe_v_d     = '0;
        pipe_id_d    = '0;
        pipe_v_d[0]  = issue_v_q;
        pipe_id_d[0] = issue_id_q;
        for (int i = 1; i < FMA_LATENCY; i++) begin
            pipe_v_d[i]  = pipe_v_q[i-1];
            pipe_id_d[i] = pipe_id_q[i-1];
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q].id    = pipe_id_q[FMA_LATENCY-1];
            mem_d[wr_ptr_q].mant  = fma_mant_i;
            mem_d[wr_ptr_q].te    = fma_te_i;
            mem_d[wr_ptr_q].trunc = fma_frac_truncated_i;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        cnt_d      = cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            cnt_q      <= '0;
            te1_q      <= '0;
            te2_q      <= '0;
            te3_q      <= '0;
            mant1_q    <= '0;
            mant2_q    <= '0;
            mant3_q    <= '0;
            opp_q      <= 1'b0;
            issue_v_q  <= 1'b0;
            issue_id_q <= '0;
            pipe_v_q   <= '0;
            pipe_id_q  <= '0;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            te1_q      <= te1_d;
            te2_q      <= te2_d;
            te3_q      <= te3_d;
            mant1_q    <= mant1_d;
            mant2_q    <= mant2_d;
            mant3_q    <= mant3_d;
            opp_q      <= opp_d;
            issue_v_q  <= issue_v_d;
            issue_id_q <= issue_id_d;
            pipe_v_q   <= pipe_v_d;
            pipe_id_q  <= pipe_id_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    assign fma_te1_o            = te1_q;
    assign fma_te2_o            = te2_q;
    assign fma_te3_o            = te3_q;
    assign fma_mant1_o          = mant1_q;
    assign fma_mant2_o          = mant2_q;
    assign fma_mant3_o          = mant3_q;
    assign fma_opp_sign_o       = opp_q;
    assign res_id_o             = mem_q[rd_ptr_q].id;
    assign res_mant_o           = mem_q[rd_ptr_q].mant;
    assign res_te_o             = mem_q[rd_ptr_q].te;
    assign res_frac_truncated_o = mem_q[rd_ptr_q].trunc;
    assign busy_o               = (cnt_q != '0);

endmodule

// File: tb/tb_fma_scheduler.sv
// Directed bench for fma_scheduler: plays the FMA with a 2-cycle model and
// scoreboards every result against operands captured at accept time.
module tb_fma_scheduler;

    localparam int NREQ = 4;
    localparam int TE   = 7;
    localparam int MS   = 14;
    localparam int MR   = 30;
    localparam int LAT  = 2;
    localparam int DEPTH = 4;
    localparam int IDW  = 2;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [NREQ-1:0]      req_valid_i;
    logic [NREQ-1:0]      req_ready_o;
    logic [NREQ*TE-1:0]   req_te1_i, req_te2_i, req_te3_i;
    logic [NREQ*MS-1:0]   req_mant1_i, req_mant2_i, req_mant3_i;
    logic [NREQ-1:0]      req_opp_sign_i;
    logic [TE-1:0]        fma_te1_o, fma_te2_o, fma_te3_o;
    logic [MS-1:0]        fma_mant1_o, fma_mant2_o, fma_mant3_o;
    logic                 fma_opp_sign_o;
    logic [MR-1:0]        fma_mant_i;
    logic [TE-1:0]        fma_te_i;
    logic                 fma_frac_truncated_i;
    logic                 res_valid_o;
    logic                 res_ready_i;
    logic [IDW-1:0]       res_id_o;
    logic [MR-1:0]        res_mant_o;
    logic [TE-1:0]        res_te_o;
    logic                 res_frac_truncated_o;
    logic                 busy_o;

    int checks = 0;
    int errors = 0;
    int seq [NREQ];
    logic [NREQ-1:0] acc_last = '0;
    int outstanding = 0;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [MR-1:0]  mant;
        logic [TE-1:0]  te;
        logic           trunc;
    } exp_t;
    exp_t sb [$];

    fma_scheduler #(
        .NREQ(NREQ), .TE_BITS(TE), .MANT_SIZE(MS), .MANT_ADD_RESULT_SIZE(MR),
        .FMA_LATENCY(LAT), .RES_DEPTH(DEPTH), .ID_W(IDW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_te1_i(req_te1_i), .req_te2_i(req_te2_i), .req_te3_i(req_te3_i),
        .req_mant1_i(req_mant1_i), .req_mant2_i(req_mant2_i), .req_mant3_i(req_mant3_i),
        .req_opp_sign_i(req_opp_sign_i),
        .fma_te1_o(fma_te1_o), .fma_te2_o(fma_te2_o), .fma_te3_o(fma_te3_o),
        .fma_mant1_o(fma_mant1_o), .fma_mant2_o(fma_mant2_o), .fma_mant3_o(fma_mant3_o),
        .fma_opp_sign_o(fma_opp_sign_o),
        .fma_mant_i(fma_mant_i), .fma_te_i(fma_te_i), .fma_frac_truncated_i(fma_frac_truncated_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_id_o(res_id_o),
        .res_mant_o(res_mant_o), .res_te_o(res_te_o),
        .res_frac_truncated_o(res_frac_truncated_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [TE-1:0] opTe1(int i, int s);  return TE'(i*11 + s*3 + 5);        endfunction
    function automatic logic [TE-1:0] opTe2(int i, int s);  return TE'(s*7 + i + 1);           endfunction
    function automatic logic [TE-1:0] opTe3(int i, int s);  return TE'(i + s);                 endfunction
    function automatic logic [MS-1:0] opM1(int i, int s);   return MS'(1000 + i*997 + s*131);  endfunction
    function automatic logic [MS-1:0] opM2(int i, int s);   return MS'(300 + i*41 + s*17);     endfunction
    function automatic logic [MS-1:0] opM3(int i, int s);   return MS'(i*2222 + s*55 + 7);     endfunction
    function automatic logic          opOpp(int i, int s);  return 1'((i + s) & 1);           endfunction

    function automatic logic [MR-1:0] fmaMant(logic [MS-1:0] a, logic [MS-1:0] b, logic [MS-1:0] c);
        return (MR'(a) * MR'(b)) + MR'(c);
    endfunction
    function automatic logic [TE-1:0] fmaTe(logic [TE-1:0] a, logic [TE-1:0] b, logic [TE-1:0] c);
        return a + b - c;
    endfunction
    function automatic logic fmaTrunc(logic [MS-1:0] a, logic opp);
        return a[0] ^ opp;
    endfunction

    function automatic exp_t expected(int i, int s);
        exp_t e;
        e.id    = IDW'(i);
        e.mant  = fmaMant(opM1(i, s), opM2(i, s), opM3(i, s));
        e.te    = fmaTe(opTe1(i, s), opTe2(i, s), opTe3(i, s));
        e.trunc = fmaTrunc(opM1(i, s), opOpp(i, s));
        return e;
    endfunction

    // Each requester presents operands derived from its own sequence number.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_te1_i[i*TE +: TE]   = opTe1(i, seq[i]);
            req_te2_i[i*TE +: TE]   = opTe2(i, seq[i]);
            req_te3_i[i*TE +: TE]   = opTe3(i, seq[i]);
            req_mant1_i[i*MS +: MS] = opM1(i, seq[i]);
            req_mant2_i[i*MS +: MS] = opM2(i, seq[i]);
            req_mant3_i[i*MS +: MS] = opM3(i, seq[i]);
            req_opp_sign_i[i]       = opOpp(i, seq[i]);
        end
    end

    logic [MR-1:0] s0_mant, s1_mant;
    logic [TE-1:0] s0_te, s1_te;
    logic          s0_tr, s1_tr;

    always @(posedge clk_i) begin
        s0_mant <= fmaMant(fma_mant1_o, fma_mant2_o, fma_mant3_o);
        s0_te   <= fmaTe(fma_te1_o, fma_te2_o, fma_te3_o);
        s0_tr   <= fmaTrunc(fma_mant1_o, fma_opp_sign_o);
        s1_mant <= s0_mant;
        s1_te   <= s0_te;
        s1_tr   <= s0_tr;
    end
    assign fma_mant_i           = s1_mant;
    assign fma_te_i             = s1_te;
    assign fma_frac_truncated_i = s1_tr;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] exp_v);
        checks++;
        assert (observed === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, exp_v);
        end
    endtask

    // Mid-cycle monitor: record accepts into the scoreboard and check every popped result.
    always @(negedge clk_i) begin
        exp_t got;
        acc_last <= '0;
        if (rst_i) begin
            sb.delete();
            outstanding = 0;
        end else begin
            checkOutput("ready_onehot", 64'($onehot0(req_ready_o)), 64'd1);
            if (res_valid_o && res_ready_i) begin
                got = '{id: res_id_o, mant: res_mant_o, te: res_te_o, trunc: res_frac_truncated_o};
                if (sb.size() == 0) begin
                    checkOutput("unexpected_result", 64'(got), 64'd0);
                end else begin
                    checkOutput("result_data", 64'(got), 64'(sb.pop_front()));
                end
                outstanding--;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid_i[i] && req_ready_o[i]) begin
                    sb.push_back(expected(i, seq[i]));
                    outstanding++;
                end
            end
            acc_last <= req_valid_i & req_ready_o;
            checks++;
            assert (outstanding <= DEPTH) else begin
                errors++;
                $error("[TB] FAIL fifo_overflow observed=%0d expected<=%0d", outstanding, DEPTH);
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_last[i]) seq[i]++;
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rdy);
        req_valid_i = valid;
        res_ready_i = rdy;
        #1;
    endtask

    task automatic resetDut();
        rst_i = 1'b1;
        applyStimulus('0, 1'b0);
        nextCycle();
        nextCycle();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        applyStimulus('0, 1'b1);
        n = 0;
        while ((busy_o || res_valid_o) && n < 40) begin
            nextCycle();
            n++;
        end
        checkOutput(tag, {62'd0, busy_o, res_valid_o}, 64'd0);
    endtask

    initial begin
        int s;
        logic [NREQ-1:0] cont_exp [11];
        cont_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1};
        for (int i = 0; i < NREQ; i++) seq[i] = 0;
        rst_i = 1'b1;
        applyStimulus('0, 1'b0);

        // Reset state
        resetDut();
        checkOutput("rst_res_valid", 64'(res_valid_o), 64'd0);
        checkOutput("rst_ready", 64'(req_ready_o), 64'd0);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_fma_ops", {fma_te1_o, fma_mant1_o, fma_mant2_o, fma_mant3_o, fma_opp_sign_o}, 64'd0);
        checkOutput("rst_res_data", {res_id_o, res_mant_o, res_te_o, res_frac_truncated_o}, 64'd0);

        // Single op: accept at cycle 0, result at cycle 4, idle at cycle 5
        s = seq[0];
        applyStimulus(4'b0001, 1'b1);
        checkOutput("single_ready", 64'(req_ready_o), 64'h1);
        nextCycle();
        applyStimulus('0, 1'b1);
        checkOutput("single_busy_c1", 64'(busy_o), 64'd1);
        checkOutput("single_fma_mant1", 64'(fma_mant1_o), 64'(opM1(0, s)));
        checkOutput("single_fma_te3", 64'(fma_te3_o), 64'(opTe3(0, s)));
        nextCycle();
        nextCycle();
        checkOutput("single_valid_c3", 64'(res_valid_o), 64'd0);
        nextCycle();
        checkOutput("single_valid_c4", 64'(res_valid_o), 64'd1);
        checkOutput("single_id", 64'(res_id_o), 64'd0);
        checkOutput("single_mant", 64'(res_mant_o), 64'(fmaMant(opM1(0, s), opM2(0, s), opM3(0, s))));
        nextCycle();
        checkOutput("single_busy_c5", 64'(busy_o), 64'd0);
        checkOutput("single_valid_c5", 64'(res_valid_o), 64'd0);

        // Contention: credit limit inserts one bubble after four back-to-back grants
        resetDut();
        for (int c = 0; c < 11; c++) begin
            applyStimulus(4'hF, 1'b1);
            checkOutput($sformatf("contend_grant_c%0d", c), 64'(req_ready_o), 64'(cont_exp[c]));
            nextCycle();
        end
        drain("contend_drain");

        // Pointer wrap: move rr to 3, then alternate between 3 and 0
        resetDut();
        applyStimulus(4'b0100, 1'b1);
        checkOutput("wrap_setup", 64'(req_ready_o), 64'h4);
        nextCycle();
        applyStimulus(4'b1001, 1'b1);
        checkOutput("wrap_grant3", 64'(req_ready_o), 64'h8);
        nextCycle();
        checkOutput("wrap_grant0", 64'(req_ready_o), 64'h1);
        nextCycle();
        checkOutput("wrap_grant3b", 64'(req_ready_o), 64'h8);
        nextCycle();
        drain("wrap_drain");

        // Backpressure: four accepts fill the credits, one pop releases exactly one more
        resetDut();
        for (int c = 0; c < 8; c++) begin
            applyStimulus(4'b0100, 1'b0);
            checkOutput($sformatf("bp_ready_c%0d", c), 64'(req_ready_o), (c < 4) ? 64'h4 : 64'h0);
            nextCycle();
        end
        checkOutput("bp_full_valid", 64'(res_valid_o), 64'd1);
        checkOutput("bp_head_id", 64'(res_id_o), 64'd2);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("bp_pop_no_grant", 64'(req_ready_o), 64'h0);
        nextCycle();
        applyStimulus(4'b0100, 1'b0);
        checkOutput("bp_regrant", 64'(req_ready_o), 64'h4);
        nextCycle();
        applyStimulus(4'b0100, 1'b0);
        checkOutput("bp_blocked_again", 64'(req_ready_o), 64'h0);
        nextCycle();
        applyStimulus('0, 1'b0);
        nextCycle();
        // Cycle 12: the re-granted op lands while the head is popped
        applyStimulus('0, 1'b1);
        checkOutput("bp_pushpop_valid", 64'(res_valid_o), 64'd1);
        nextCycle();
        checkOutput("bp_after_pushpop", 64'(res_valid_o), 64'd1);
        drain("bp_drain");

        // Reset with three ops in flight
        resetDut();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'hF, 1'b1);
            checkOutput($sformatf("rstmid_grant_c%0d", c), 64'(req_ready_o), 64'(1) << c);
            nextCycle();
        end
        rst_i = 1'b1;
        applyStimulus('0, 1'b1);
        nextCycle();
        rst_i = 1'b0;
        #1;
        checkOutput("rstmid_outputs", {req_ready_o, res_valid_o, busy_o, res_id_o, fma_mant1_o}, 64'd0);
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("rstmid_quiet_c%0d", c), {62'd0, res_valid_o, busy_o}, 64'd0);
            nextCycle();
        end
        applyStimulus(4'hF, 1'b1);
        checkOutput("rstmid_rr_zero", 64'(req_ready_o), 64'h1);
        nextCycle();
        drain("rstmid_drain");

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
